// File: rtl/mmu_pkg.sv
// Shared types for the MMU/TLB slice.
// PTE bit positions, walker FSM states and the TLB entry layout.
package mmu_pkg;

  localparam int PTE_V = 0;
  localparam int PTE_W = 1;
  localparam int TLB_TAG_W = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WALK,
    S_RESP
  } state_e;

  typedef struct packed {
    logic                 v;
    logic                 w;
    logic [TLB_TAG_W-1:0] vpn;
    logic [TLB_TAG_W-1:0] ppn;
  } tlb_entry_t;

endpackage

// File: rtl/mmu_tlb_array.sv
// Fully-associative TLB storage with parallel compare.
// Round-robin refill; flush drops valid bits but keeps the pointer.
module mmu_tlb_array
  import mmu_pkg::*;
#(
  parameter int ENTRIES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [TLB_TAG_W-1:0] lookup_vpn,
  output logic                 hit,
  output logic [TLB_TAG_W-1:0] hit_ppn,
  output logic                 hit_w,
  input  logic                 fill_en,
  input  logic [TLB_TAG_W-1:0] fill_vpn,
  input  logic [TLB_TAG_W-1:0] fill_ppn,
  input  logic                 fill_w
);

  localparam int PW = $clog2(ENTRIES);

  tlb_entry_t     ent [ENTRIES];
  logic [PW-1:0]  ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) ent[i] <= '0;
      ptr <= '0;
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) ent[i].v <= 1'b0;
    end else if (fill_en) begin
      ent[ptr].v   <= 1'b1;
      ent[ptr].w   <= fill_w;
      ent[ptr].vpn <= fill_vpn;
      ent[ptr].ppn <= fill_ppn;
      ptr <= (ptr == PW'(ENTRIES - 1)) ? '0 : ptr + 1'b1;
    end
  end

  // Only misses install, so at most one entry matches and OR-ing is safe.
  always_comb begin
    hit     = 1'b0;
    hit_ppn = '0;
    hit_w   = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (ent[i].v && ent[i].vpn == lookup_vpn) begin
        hit     = 1'b1;
        hit_ppn = hit_ppn | ent[i].ppn;
        hit_w   = hit_w | ent[i].w;
      end
    end
  end

endmodule

// File: rtl/mmu_tlb.sv
// Address-translation unit: TLB lookup plus single-level page walk.
// Optional store protection via MMU_WRITE_PROT_EN.
module mmu_tlb
  import mmu_pkg::*;
#(
  parameter int          VA_W        = 32,
  parameter int          PA_W        = 32,
  parameter int          PAGE_BITS   = 12,
  parameter int          TLB_ENTRIES = 4,
  parameter logic [31:0] PT_BASE     = 32'h0000_1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [VA_W-1:0] req_vaddr,
  input  logic            req_write,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [PA_W-1:0] rsp_paddr,
  output logic            rsp_fault,
  output logic            pt_rd_en,
  output logic [31:0]     pt_rd_addr,
  input  logic            pt_rd_valid,
  input  logic [31:0]     pt_rd_data,
  input  logic            flush
);

  localparam int VPN_W = VA_W - PAGE_BITS;
  localparam int PPN_W = PA_W - PAGE_BITS;

  state_e state, state_nx;

  logic [VPN_W-1:0]     vpn_q;
  logic [PAGE_BITS-1:0] off_q;
  logic                 write_q;
  logic                 first_q;
  logic                 flushed_q;

  logic                 hit;
  logic                 hit_w;
  logic [TLB_TAG_W-1:0] hit_ppn;
  logic [TLB_TAG_W-1:0] req_vpn;
  logic [PPN_W-1:0]     pte_ppn;
  logic                 accept;
  logic                 fill_en;
  logic                 fill_w;
  logic                 hit_fault;
  logic                 pte_fault;
  logic                 unused_ok;

  assign req_vpn = TLB_TAG_W'(req_vaddr[VA_W-1:PAGE_BITS]);
  assign pte_ppn = pt_rd_data[PAGE_BITS +: PPN_W];
  assign accept  = req_valid && req_ready;

`ifdef MMU_WRITE_PROT_EN
  assign hit_fault = req_write && !hit_w;
  assign pte_fault = !pt_rd_data[PTE_V] ||
                     (write_q && !pt_rd_data[PTE_W]);
  assign fill_w    = pt_rd_data[PTE_W];
`else
  assign hit_fault = 1'b0;
  assign pte_fault = !pt_rd_data[PTE_V];
  assign fill_w    = 1'b0;
`endif

  assign unused_ok = ^{pt_rd_data, hit_ppn, hit_w, req_write, write_q};

  // A flush seen anywhere in the walk suppresses the install.
  assign fill_en = (state == S_WALK) && pt_rd_valid &&
                   pt_rd_data[PTE_V] && !flush && !flushed_q;

  mmu_tlb_array #(
    .ENTRIES(TLB_ENTRIES)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .lookup_vpn(req_vpn),
    .hit       (hit),
    .hit_ppn   (hit_ppn),
    .hit_w     (hit_w),
    .fill_en   (fill_en),
    .fill_vpn  (TLB_TAG_W'(vpn_q)),
    .fill_ppn  (TLB_TAG_W'(pte_ppn)),
    .fill_w    (fill_w)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (accept) state_nx = hit ? S_RESP : S_WALK;
      S_WALK: if (pt_rd_valid) state_nx = S_RESP;
      S_RESP: if (rsp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == S_IDLE) && !flush;
    rsp_valid = (state == S_RESP);
    pt_rd_en  = (state == S_WALK) && first_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vpn_q      <= '0;
      off_q      <= '0;
      write_q    <= 1'b0;
      first_q    <= 1'b0;
      flushed_q  <= 1'b0;
      pt_rd_addr <= '0;
      rsp_paddr  <= '0;
      rsp_fault  <= 1'b0;
    end else begin
      if (accept) begin
        vpn_q     <= req_vaddr[VA_W-1:PAGE_BITS];
        off_q     <= req_vaddr[PAGE_BITS-1:0];
        write_q   <= req_write;
        first_q   <= !hit;
        flushed_q <= 1'b0;
        if (hit) begin
          rsp_fault <= hit_fault;
          rsp_paddr <= hit_fault ? '0 :
                       {hit_ppn[PPN_W-1:0], req_vaddr[PAGE_BITS-1:0]};
        end else begin
          pt_rd_addr <= PT_BASE + (req_vpn << 2);
        end
      end
      if (state == S_WALK) begin
        first_q <= 1'b0;
        if (flush) flushed_q <= 1'b1;
        if (pt_rd_valid) begin
          rsp_fault <= pte_fault;
          rsp_paddr <= pte_fault ? '0 : {pte_ppn, off_q};
        end
      end
    end
  end

endmodule

// File: tb/tb_mmu_tlb.sv
// Directed testbench for mmu_tlb (default parameters).
// Expectations follow MMU_WRITE_PROT_EN when it is defined.
module tb_mmu_tlb;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_vaddr;
  logic        req_write;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_paddr;
  logic        rsp_fault;
  logic        pt_rd_en;
  logic [31:0] pt_rd_addr;
  logic        pt_rd_valid;
  logic [31:0] pt_rd_data;
  logic        flush;

  int checks = 0;
  int failures = 0;

`ifdef MMU_WRITE_PROT_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  always #5 clk = ~clk;

  mmu_tlb dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_vaddr  (req_vaddr),
    .req_write  (req_write),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_paddr  (rsp_paddr),
    .rsp_fault  (rsp_fault),
    .pt_rd_en   (pt_rd_en),
    .pt_rd_addr (pt_rd_addr),
    .pt_rd_valid(pt_rd_valid),
    .pt_rd_data (pt_rd_data),
    .flush      (flush)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [31:0] va, input logic wr,
                        input string tag);
    req_valid = 1'b1;
    req_vaddr = va;
    req_write = wr;
    #1;
    chk({tag, "_rdy"}, 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    req_write = 1'b0;
  endtask

  task automatic walk(input logic [31:0] va, input logic wr,
                      input logic [31:0] pte, input int lat,
                      input logic [31:0] addr, input logic [31:0] pa,
                      input logic flt, input string tag);
    do_req(va, wr, tag);
    chk({tag, "_en"}, 32'(pt_rd_en), 32'd1);
    chk({tag, "_addr"}, pt_rd_addr, addr);
    chk({tag, "_vld0"}, 32'(rsp_valid), 32'd0);
    for (int i = 0; i < lat; i++) begin
      tick();
      chk({tag, "_en_off"}, 32'(pt_rd_en), 32'd0);
    end
    pt_rd_valid = 1'b1;
    pt_rd_data  = pte;
    tick();
    pt_rd_valid = 1'b0;
    chk({tag, "_vld"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_pa"}, rsp_paddr, pa);
    chk({tag, "_flt"}, 32'(rsp_fault), 32'(flt));
    tick();
  endtask

  task automatic lookup(input logic [31:0] va, input logic wr,
                        input logic [31:0] pa, input logic flt,
                        input string tag);
    do_req(va, wr, tag);
    chk({tag, "_vld"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_en"}, 32'(pt_rd_en), 32'd0);
    chk({tag, "_pa"}, rsp_paddr, pa);
    chk({tag, "_flt"}, 32'(rsp_fault), 32'(flt));
    tick();
  endtask

  task automatic flush_idle(input string tag);
    flush     = 1'b1;
    req_valid = 1'b1;
    req_vaddr = 32'h0000_3010;
    #1;
    chk({tag, "_rdy0"}, 32'(req_ready), 32'd0);
    tick();
    flush     = 1'b0;
    req_valid = 1'b0;
    #1;
    chk({tag, "_vld"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_en"}, 32'(pt_rd_en), 32'd0);
    chk({tag, "_rdy1"}, 32'(req_ready), 32'd1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rdy"}, 32'(req_ready), 32'd1);
    chk({tag, "_vld"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_pa"}, rsp_paddr, 32'd0);
    chk({tag, "_flt"}, 32'(rsp_fault), 32'd0);
    chk({tag, "_en"}, 32'(pt_rd_en), 32'd0);
    chk({tag, "_addr"}, pt_rd_addr, 32'd0);
  endtask

  initial begin
    logic [31:0] k;
    rst = 1'b1;
    req_valid = 1'b0;
    req_vaddr = '0;
    req_write = 1'b0;
    rsp_ready = 1'b1;
    pt_rd_valid = 1'b0;
    pt_rd_data = '0;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b0;
    tick();

    walk(32'h0000_3ABC, 1'b0, 32'h0002_5003, 2, 32'h100C,
         32'h0002_5ABC, 1'b0, "miss");
    lookup(32'h0000_3004, 1'b0, 32'h0002_5004, 1'b0, "hit");

    walk(32'h0000_7000, 1'b0, 32'h0, 0, 32'h101C, 32'h0, 1'b1, "inv");
    walk(32'h0000_7000, 1'b0, 32'h0, 1, 32'h101C, 32'h0, 1'b1, "inv2");

    flush_idle("fl_idle");
    walk(32'h0000_3010, 1'b0, 32'h0002_5003, 0, 32'h100C,
         32'h0002_5010, 1'b0, "fl_rewalk");

    flush_idle("fl_repl");
    for (int i = 1; i <= 5; i++) begin
      k = 32'(i);
      walk((k << 12) | 32'h10, 1'b0, ((32'h40 + k) << 12) | 32'h1, 0,
           32'h1000 + (k << 2), ((32'h40 + k) << 12) | 32'h10, 1'b0,
           "fill");
    end
    walk(32'h0000_1010, 1'b0, 32'h0004_1001, 0, 32'h1004,
         32'h0004_1010, 1'b0, "evicted");
    for (int i = 3; i <= 5; i++) begin
      k = 32'(i);
      lookup((k << 12) | 32'h20, 1'b0, ((32'h40 + k) << 12) | 32'h20,
             1'b0, "kept");
    end

    do_req(32'h0000_6000, 1'b0, "flw");
    chk("flw_en", 32'(pt_rd_en), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flw_vld0", 32'(rsp_valid), 32'd0);
    pt_rd_valid = 1'b1;
    pt_rd_data  = 32'h0006_6001;
    tick();
    pt_rd_valid = 1'b0;
    chk("flw_vld", 32'(rsp_valid), 32'd1);
    chk("flw_pa", rsp_paddr, 32'h0006_6000);
    tick();
    walk(32'h0000_6000, 1'b0, 32'h0006_6001, 0, 32'h1018,
         32'h0006_6000, 1'b0, "flw_again");

    rsp_ready = 1'b0;
    do_req(32'h0000_6123, 1'b0, "bp");
    for (int i = 0; i < 3; i++) begin
      chk("bp_vld", 32'(rsp_valid), 32'd1);
      chk("bp_pa", rsp_paddr, 32'h0006_6123);
      chk("bp_rdy", 32'(req_ready), 32'd0);
      if (i < 2) tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_done", 32'(rsp_valid), 32'd0);
    chk("bp_rdy1", 32'(req_ready), 32'd1);

    do_req(32'h0000_9000, 1'b0, "rstw");
    chk("rstw_en", 32'(pt_rd_en), 32'd1);
    rst = 1'b1;
    #1;
    chk_reset("rstw");
    pt_rd_valid = 1'b1;
    pt_rd_data  = 32'h0009_9001;
    tick();
    rst = 1'b0;
    tick();
    chk("late_vld", 32'(rsp_valid), 32'd0);
    chk("late_en", 32'(pt_rd_en), 32'd0);
    chk("late_rdy", 32'(req_ready), 32'd1);
    pt_rd_valid = 1'b0;
    walk(32'h0000_3010, 1'b0, 32'h0002_5003, 0, 32'h100C,
         32'h0002_5010, 1'b0, "post_rst");
    walk(32'h0000_9000, 1'b0, 32'h0009_9001, 0, 32'h1024,
         32'h0009_9000, 1'b0, "late_noinst");

    flush_idle("fl_wp");
    walk(32'h0000_3000, 1'b1, 32'h0002_5001, 0, 32'h100C,
         WP ? 32'h0 : 32'h0002_5000, WP, "wp_walk");
    lookup(32'h0000_3000, 1'b0, 32'h0002_5000, 1'b0, "wp_load");
    lookup(32'h0000_3000, 1'b1, WP ? 32'h0 : 32'h0002_5000, WP,
           "wp_store");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
